// File: rtl/ras_pkg.sv
// Shared types and constants for the return-address-stack control stage.
// Command din is carried at RAS_W bits; the top casts to its WIDTH.
package ras_pkg;

  localparam int RAS_W = 32;
  localparam int unsigned RET_OFS_RVC = 2;
  localparam int unsigned RET_OFS_STD = 4;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    FLUSH
  } ras_ctrl_state_e;

  typedef struct packed {
    logic             push;
    logic             pop;
    logic             branch;
    logic [RAS_W-1:0] din;
  } ras_cmd_t;

endpackage

// File: rtl/ras_close_sched.sv
// Close scheduler: counts resolved-correct closes and spaces them
// so that no two close_valid pulses are issued back to back.
module ras_close_sched
  import ras_pkg::*;
#(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          clr,
  output logic          close_valid,
  output logic          busy,
  output logic [CW-1:0] pending
);

  logic [CW-1:0] pend_q;
  logic          last_q;

  assign close_valid = (pend_q != '0) && !last_q;
  assign busy        = (pend_q != '0) || close_valid;
  assign pending     = pend_q;

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      pend_q <= '0;
      last_q <= 1'b0;
    end else begin
      pend_q <= pend_q + CW'(inc) - CW'(close_valid);
      last_q <= close_valid;
    end
  end

endmodule

// File: rtl/ras_ctrl.sv
// RAS control stage: fetch/resolve events to RAS commands + return
// prediction. Define RAS_CTRL_COROUTINE_EN for call+ret push-and-pop.
module ras_ctrl
  import ras_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int MAX_BRANCHES  = 16,
  parameter int ADDR_BRANCHES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_valid,
  output logic             fetch_ready,
  input  logic             fetch_call,
  input  logic             fetch_ret,
  input  logic             fetch_cbr,
  input  logic             fetch_rvc,
  input  logic [WIDTH-1:0] fetch_pc,
  input  logic             resolve_valid,
  input  logic             resolve_mispredict,
  output logic             ras_push,
  output logic             ras_pop,
  output logic             ras_branch,
  output logic             ras_close_valid,
  output logic             ras_close_invalid,
  output logic [WIDTH-1:0] ras_din,
  input  logic [WIDTH-1:0] ras_dout,
  input  logic             ras_empty,
  output logic             pred_valid,
  output logic             pred_hit,
  output logic [WIDTH-1:0] pred_target
);

  localparam int CW = ADDR_BRANCHES + 1;

  ras_ctrl_state_e state_q, state_d;
  ras_cmd_t        cmd_q, cmd_d;

  logic [CW-1:0]    outst_q;
  logic [CW-1:0]    pending;
  logic [CW-1:0]    occ;
  logic [WIDTH-1:0] ret_addr;
  logic             pred_v_q;
  logic             pred_hit_q;
  logic             mis;
  logic             full;
  logic             accept;
  logic             do_pop;
  logic             close_valid;
  logic             busy;
  logic             flush;

  assign mis   = resolve_valid && resolve_mispredict;
  assign flush = (state_q == FLUSH);
  assign occ   = outst_q + pending;
  assign full  = (occ == CW'(MAX_BRANCHES));

  // A mispredict blocks fetch at once so the stage is empty at flush.
  assign fetch_ready = (state_q == RUN) && !mis
                    && !(fetch_cbr && full);
  assign accept = fetch_valid && fetch_ready;

  assign ret_addr = fetch_pc + (fetch_rvc ? WIDTH'(RET_OFS_RVC)
                                          : WIDTH'(RET_OFS_STD));

`ifdef RAS_CTRL_COROUTINE_EN
  assign do_pop = fetch_ret;
`else
  assign do_pop = fetch_ret && !fetch_call;
`endif

  always_comb begin
    cmd_d = '0;
    if (accept) begin
      cmd_d.push   = fetch_call;
      cmd_d.pop    = do_pop;
      cmd_d.branch = fetch_cbr;
      cmd_d.din    = fetch_call ? RAS_W'(ret_addr) : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (mis) state_d = (busy || close_valid) ? DRAIN : FLUSH;
      end
      DRAIN: begin
        if (!busy) state_d = FLUSH;
      end
      FLUSH: state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      outst_q <= '0;
      cmd_q   <= '0;
    end else begin
      outst_q <= outst_q + CW'(accept && fetch_cbr)
                         - CW'(resolve_valid);
      cmd_q   <= cmd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pred_v_q   <= 1'b0;
      pred_hit_q <= 1'b0;
    end else begin
      pred_v_q   <= cmd_q.pop;
      pred_hit_q <= cmd_q.pop && !ras_empty;
    end
  end

  ras_close_sched #(.CW(CW)) u_sched (
    .clk        (clk),
    .reset      (reset),
    .inc        (resolve_valid && !resolve_mispredict),
    .clr        (flush),
    .close_valid(close_valid),
    .busy       (busy),
    .pending    (pending)
  );

  assign ras_push          = cmd_q.push;
  assign ras_pop           = cmd_q.pop;
  assign ras_branch        = cmd_q.branch;
  assign ras_din           = WIDTH'(cmd_q.din);
  assign ras_close_valid   = close_valid;
  assign ras_close_invalid = flush;
  assign pred_valid        = pred_v_q;
  assign pred_hit          = pred_hit_q;
  assign pred_target       = pred_hit_q ? ras_dout : '0;

endmodule

// File: tb/tb_ras_ctrl.sv
// Scoreboard bench for ras_ctrl with a small behavioural RAS.
// Directed vectors push expected events; a monitor pops and compares.
module tb_ras_ctrl;
  import ras_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_valid = 1'b0;
  logic        fetch_ready;
  logic        fetch_call = 1'b0;
  logic        fetch_ret = 1'b0;
  logic        fetch_cbr = 1'b0;
  logic        fetch_rvc = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        resolve_valid = 1'b0;
  logic        resolve_mispredict = 1'b0;
  logic        ras_push, ras_pop, ras_branch;
  logic        ras_close_valid, ras_close_invalid;
  logic [31:0] ras_din;
  logic [31:0] ras_dout;
  logic        ras_empty;
  logic        pred_valid, pred_hit;
  logic [31:0] pred_target;

  ras_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .fetch_valid       (fetch_valid),
    .fetch_ready       (fetch_ready),
    .fetch_call        (fetch_call),
    .fetch_ret         (fetch_ret),
    .fetch_cbr         (fetch_cbr),
    .fetch_rvc         (fetch_rvc),
    .fetch_pc          (fetch_pc),
    .resolve_valid     (resolve_valid),
    .resolve_mispredict(resolve_mispredict),
    .ras_push          (ras_push),
    .ras_pop           (ras_pop),
    .ras_branch        (ras_branch),
    .ras_close_valid   (ras_close_valid),
    .ras_close_invalid (ras_close_invalid),
    .ras_din           (ras_din),
    .ras_dout          (ras_dout),
    .ras_empty         (ras_empty),
    .pred_valid        (pred_valid),
    .pred_hit          (pred_hit),
    .pred_target       (pred_target)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAS: registered read of the popped entry.
  logic [31:0] stk [32];
  int          cnt = 0;
  logic [31:0] dout_r = '0;
  assign ras_empty = (cnt == 0);
  assign ras_dout  = dout_r;

  always @(posedge clk) begin
    if (ras_close_invalid) begin
      cnt <= 0;
    end else begin
      if (ras_pop)
        dout_r <= (cnt != 0) ? stk[cnt-1] : 32'hdead_beef;
      if (ras_push && ras_pop) begin
        if (cnt != 0) stk[cnt-1] <= ras_din;
        else begin
          stk[0] <= ras_din;
          cnt <= 1;
        end
      end else if (ras_push) begin
        stk[cnt] <= ras_din;
        cnt <= cnt + 1;
      end else if (ras_pop && cnt != 0) begin
        cnt <= cnt - 1;
      end
    end
  end

  always @(posedge clk) begin
    if (reset && resolve_valid)
      assert (dut.state_q == RUN && dut.outst_q != '0)
        else $error("resolve_valid outside RUN or none outstanding");
  end

  typedef struct {
    int cyc;
    logic push, pop, branch;
    logic [31:0] din;
  } cmd_e;
  typedef struct {
    int   cyc;
    logic inv;
  } cls_e;
  typedef struct {
    int cyc;
    logic hit;
    logic [31:0] tgt;
  } prd_e;

  cmd_e cmdq[$];
  cls_e clsq[$];
  prd_e prdq[$];
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  task automatic exp_cmd(input int c, input logic pu, po, br,
                         input logic [31:0] d);
    cmd_e e;
    e.cyc = c; e.push = pu; e.pop = po; e.branch = br; e.din = d;
    cmdq.push_back(e);
  endtask

  task automatic exp_cls(input int c, input logic inv);
    cls_e e;
    e.cyc = c; e.inv = inv;
    clsq.push_back(e);
  endtask

  task automatic exp_prd(input int c, input logic h,
                         input logic [31:0] t);
    prd_e e;
    e.cyc = c; e.hit = h; e.tgt = t;
    prdq.push_back(e);
  endtask

  cmd_e mc;
  cls_e ml;
  prd_e mp;

  always @(negedge clk) begin
    if (mon_en) begin
      while (cmdq.size() > 0 && cmdq[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL cmd_missing exp_cyc=%0d now=%0d",
                 cmdq[0].cyc, cyc);
        void'(cmdq.pop_front());
      end
      while (clsq.size() > 0 && clsq[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL close_missing exp_cyc=%0d inv=%0b now=%0d",
                 clsq[0].cyc, clsq[0].inv, cyc);
        void'(clsq.pop_front());
      end
      while (prdq.size() > 0 && prdq[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL pred_missing exp_cyc=%0d now=%0d",
                 prdq[0].cyc, cyc);
        void'(prdq.pop_front());
      end
      if (ras_push || ras_pop || ras_branch) begin
        checks++;
        if (cmdq.size() == 0) begin
          errors++;
          $display("FAIL cmd_unexpected p=%0b o=%0b b=%0b cyc=%0d",
                   ras_push, ras_pop, ras_branch, cyc);
        end else begin
          mc = cmdq.pop_front();
          if (mc.cyc != cyc || mc.push != ras_push ||
              mc.pop != ras_pop || mc.branch != ras_branch ||
              (ras_push && mc.din != ras_din)) begin
            errors++;
            $display("FAIL cmd act cyc=%0d pob=%0b%0b%0b din=%h exp cyc=%0d pob=%0b%0b%0b din=%h",
                     cyc, ras_push, ras_pop, ras_branch, ras_din,
                     mc.cyc, mc.push, mc.pop, mc.branch, mc.din);
          end
        end
      end
      if (ras_close_valid || ras_close_invalid) begin
        checks++;
        if (clsq.size() == 0) begin
          errors++;
          $display("FAIL close_unexpected v=%0b i=%0b cyc=%0d",
                   ras_close_valid, ras_close_invalid, cyc);
        end else begin
          ml = clsq.pop_front();
          if (ml.cyc != cyc || ras_close_invalid != ml.inv ||
              ras_close_valid != !ml.inv) begin
            errors++;
            $display("FAIL close act cyc=%0d v=%0b i=%0b exp cyc=%0d inv=%0b",
                     cyc, ras_close_valid, ras_close_invalid,
                     ml.cyc, ml.inv);
          end
        end
      end
      if (ras_close_invalid &&
          (ras_push || ras_pop || ras_branch || ras_close_valid)) begin
        checks++; errors++;
        $display("FAIL close_invalid_overlap cyc=%0d", cyc);
      end
      if (pred_valid) begin
        checks++;
        if (prdq.size() == 0) begin
          errors++;
          $display("FAIL pred_unexpected hit=%0b tgt=%h cyc=%0d",
                   pred_hit, pred_target, cyc);
        end else begin
          mp = prdq.pop_front();
          if (mp.cyc != cyc || mp.hit != pred_hit ||
              mp.tgt != pred_target) begin
            errors++;
            $display("FAIL pred act cyc=%0d hit=%0b tgt=%h exp cyc=%0d hit=%0b tgt=%h",
                     cyc, pred_hit, pred_target,
                     mp.cyc, mp.hit, mp.tgt);
          end
        end
      end
    end
  end

  task automatic step(input logic fv, call, ret, cbr, rvc,
                      input logic [31:0] pc,
                      input logic rv, rm, rdy);
    fetch_valid = fv; fetch_call = call; fetch_ret = ret;
    fetch_cbr = cbr; fetch_rvc = rvc; fetch_pc = pc;
    resolve_valid = rv; resolve_mispredict = rm;
    @(negedge clk);
    chk("fetch_ready", {31'd0, fetch_ready}, {31'd0, rdy});
    @(posedge clk);
    #1;
    fetch_valid = 0; fetch_call = 0; fetch_ret = 0;
    fetch_cbr = 0; fetch_rvc = 0; fetch_pc = '0;
    resolve_valid = 0; resolve_mispredict = 0;
  endtask

  task automatic idle(input logic rdy);
    step(0, 0, 0, 0, 0, '0, 0, 0, rdy);
  endtask

  task automatic fslot(input logic call, ret, cbr, rvc,
                       input logic [31:0] pc, input logic rdy);
    step(1, call, ret, cbr, rvc, pc, 0, 0, rdy);
  endtask

  task automatic res(input logic mis, input logic rdy);
    step(0, 0, 0, 0, 0, '0, 1, mis, rdy);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int m;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, fetch_ready}, 32'd1);
    chk("rst_cmds",
        {27'd0, ras_push, ras_pop, ras_branch,
         ras_close_valid, ras_close_invalid}, 32'd0);
    chk("rst_pred", {30'd0, pred_valid, pred_hit}, 32'd0);
    chk("rst_din", ras_din, 32'd0);
    reset = 1'b1;
    mon_en = 1'b1;
    idle(1);

    // call then ret
    exp_cmd(cyc + 1, 1, 0, 0, 32'h104);
    fslot(1, 0, 0, 0, 32'h100, 1);
    exp_cmd(cyc + 1, 0, 1, 0, '0);
    exp_prd(cyc + 2, 1, 32'h104);
    fslot(0, 1, 0, 0, 32'h110, 1);
    repeat (3) idle(1);

    // fill branch list
    for (int k = 0; k < 16; k++) begin
      exp_cmd(cyc + 1, 0, 0, 1, '0);
      fslot(0, 0, 1, 0, 32'h1000 + 32'(4 * k), 1);
    end
    fslot(0, 0, 1, 0, 32'h1040, 0);
    exp_cmd(cyc + 1, 1, 0, 0, 32'h204);
    fslot(1, 0, 0, 0, 32'h200, 1);
    repeat (2) idle(1);

    // three back-to-back correct resolves
    exp_cls(cyc + 1, 0);
    exp_cls(cyc + 3, 0);
    exp_cls(cyc + 5, 0);
    repeat (3) res(0, 1);
    repeat (4) idle(1);

    // two correct resolves then mispredict
    exp_cls(cyc + 1, 0);
    m = cyc + 2;
    exp_cls(m + 1, 0);
    exp_cls(m + 3, 1);
    res(0, 1);
    res(0, 1);
    step(1, 0, 0, 0, 0, 32'h300, 1, 1, 0);
    repeat (3) fslot(0, 0, 0, 0, 32'h300, 0);
    fslot(0, 0, 0, 0, 32'h300, 1);
    idle(1);

    // rvc call flushed, then ret on empty RAS
    exp_cmd(cyc + 1, 0, 0, 1, '0);
    fslot(0, 0, 1, 0, 32'h400, 1);
    exp_cmd(cyc + 1, 1, 0, 0, 32'h412);
    fslot(1, 0, 0, 1, 32'h410, 1);
    idle(1);
    exp_cls(cyc + 1, 1);
    res(1, 0);
    idle(0);
    exp_cmd(cyc + 1, 0, 1, 0, '0);
    exp_prd(cyc + 2, 0, 32'h0);
    fslot(0, 1, 0, 0, 32'h420, 1);
    repeat (3) idle(1);

    // coroutine slot
    exp_cmd(cyc + 1, 1, 0, 0, 32'h604);
    fslot(1, 0, 0, 0, 32'h600, 1);
`ifdef RAS_CTRL_COROUTINE_EN
    exp_cmd(cyc + 1, 1, 1, 0, 32'h504);
    exp_prd(cyc + 2, 1, 32'h604);
`else
    exp_cmd(cyc + 1, 1, 0, 0, 32'h504);
`endif
    fslot(1, 1, 0, 0, 32'h500, 1);
    repeat (3) idle(1);

    // reset while draining
    exp_cmd(cyc + 1, 0, 0, 1, '0);
    fslot(0, 0, 1, 0, 32'h700, 1);
    exp_cmd(cyc + 1, 0, 0, 1, '0);
    fslot(0, 0, 1, 0, 32'h704, 1);
    exp_cls(cyc + 1, 0);
    res(0, 1);
    res(1, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    fslot(0, 0, 0, 0, 32'h800, 1);
    repeat (4) idle(1);

    chk("cmdq_left", cmdq.size(), 0);
    chk("clsq_left", clsq.size(), 0);
    chk("prdq_left", prdq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ras_ctrl.md
# ras_ctrl

Front-end control stage sitting directly upstream of the return address stack. It converts the accepted fetch stream (calls, returns, conditional branches) and in-order back-end resolution events into the RAS command set: push, pop, branch, close_valid and close_invalid. It also returns the predicted return target to fetch. It enforces the RAS rules the stack cannot enforce itself: branch-list capacity, spacing between closes, and draining older closes before a rollback.

## Interface
Parameters:
- WIDTH, 32, return-address width
- MAX_BRANCHES, 16, RAS branch-list capacity; maximum speculation points tracked
- ADDR_BRANCHES, 4, log2(MAX_BRANCHES)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low
- fetch_valid  in  1  fetch slot valid
- fetch_ready  out  1  slot accepted when valid && ready
- fetch_call  in  1  slot is a call
- fetch_ret  in  1  slot is a return
- fetch_cbr  in  1  slot is a conditional branch (speculation point)
- fetch_rvc  in  1  slot is a 16-bit instruction
- fetch_pc  in  WIDTH  slot PC
- resolve_valid  in  1  oldest outstanding cbr resolved (in order)
- resolve_mispredict  in  1  qualifies resolve_valid
- ras_push, ras_pop, ras_branch, ras_close_valid, ras_close_invalid  out  1  RAS commands
- ras_din  out  WIDTH  return address to push
- ras_dout  in  WIDTH  RAS top-of-stack data
- ras_empty  in  1  RAS empty flag
- pred_valid  out  1  return prediction strobe
- pred_hit  out  1  RAS was non-empty at the pop
- pred_target  out  WIDTH  predicted return address

## Operation
- Acceptance at cycle T is registered into a command stage.
- The commands are driven at T+1:
  - call: ras_push, with ras_din = fetch_pc + (fetch_rvc ? 2 : 4), truncated to WIDTH
  - ret: ras_pop
  - cbr: ras_branch
- A call and a ret in the same slot follow the Configuration section.
- Counters, each ADDR_BRANCHES+1 bits wide:
  - outstanding: incremented on accepted cbr, decremented on resolve_valid
  - pending: resolved-correct closes not yet issued
- occupancy = outstanding + pending. fetch_ready is deasserted for a cbr slot when occupancy == MAX_BRANCHES; non-branch slots are still accepted.
- Correct resolve increments pending. The close scheduler issues ras_close_valid when pending > 0 and no close was issued in the previous cycle, giving at most one close per two cycles.
- State machine, all transitions on clk:
  - RUN: normal operation. On resolve_valid && resolve_mispredict, go to DRAIN if pending > 0 or a close was issued this cycle; otherwise go to FLUSH.
  - DRAIN: fetch_ready = 0 and the scheduler keeps issuing closes. When pending == 0 and there was no close in the previous cycle, go to FLUSH.
  - FLUSH: ras_close_invalid = 1 for exactly one cycle; outstanding and pending are cleared and the command stage is cleared; fetch_ready = 0; next state is RUN.
- fetch_ready is also deasserted combinationally in any cycle with resolve_valid && resolve_mispredict. This guarantees the command stage is empty whenever close_invalid is driven.
- resolve_valid must be 0 outside RUN and must only be asserted when outstanding > 0. A bench assertion flags violations.
- A pop is recorded as pending_pred at T+1 together with pred_hit = !ras_empty. At T+2: pred_valid = 1 and pred_target = ras_dout (or 0 when pred_hit = 0).

## Timing
- Reset values: state RUN, counters 0, every output 0 except fetch_ready = 1.
- Acceptance to RAS command: 1 cycle. Acceptance of a ret to pred_valid: 2 cycles.
- Mispredict at cycle M with nothing pending: ras_close_invalid at M+1. If a close was issued at M, close_invalid is at M+2.
- close_valid and branch may coincide. close_invalid never coincides with push, pop, branch or close_valid.
- A close_valid is never issued in the cycle directly after another close_valid or directly before close_invalid.
- Reset mid-DRAIN or mid-FLUSH returns to RUN with counters 0 and issues no RAS command.

## Configuration
- RAS_CTRL_COROUTINE_EN defined: a call+ret slot drives ras_push and ras_pop in the same cycle; the prediction is produced as for a ret.
- RAS_CTRL_COROUTINE_EN not defined: a call+ret slot is treated as a call only (push, no pop, no prediction).

## Structure
- Package ras_pkg holds:
  - ras_ctrl_state_e enum: RUN, DRAIN, FLUSH
  - ras_cmd_t struct: push, pop, branch, din
  - the 2/4-byte return-offset constants
- One sub-module, ras_close_sched: owns the pending counter and the one-cycle gap logic; outputs close_valid and a busy flag.

## Test plan
- Call at PC 0x100, then ret → push with din 0x104 at T+1; pop at T'+1; pred_valid, pred_hit = 1, pred_target = 0x104 at T'+2.
- 16 cbrs accepted, none resolved → the 17th cbr stalls with fetch_ready = 0; a non-branch slot in the same state is still accepted.
- Three back-to-back correct resolves → ras_close_valid in cycles R+1, R+3, R+5; pending returns to 0.
- Two correct resolves followed immediately by a mispredict → both closes drained, then exactly one close_invalid; no fetch accepted from M until the cycle after close_invalid.
- Ret on an empty RAS (rvc call earlier flushed) → pred_valid = 1, pred_hit = 0, pred_target = 0.
- Coroutine slot: with RAS_CTRL_COROUTINE_EN, push and pop are asserted together; without it, push only and pred_valid stays 0.
